// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: word array plus memory-mapped I/O at 0xFFFF (switches / hex display).
// Latency: R pulses during the cycle after edge t0+1+WAIT_STATES, where t0 is the acceptance edge.
// Backpressure: one request in flight; MEM_EN is ignored outside IDLE. MEM_OOR_FLAG_EN adds a sticky oor_err output.
module lc3_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        MEM_EN,
    input  logic        WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic        R,
    output logic [15:0] HEX_out
`ifdef MEM_OOR_FLAG_EN
    ,
    output logic        oor_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [15:0]       addr_q;
    logic [15:0]       wdat_q;
    logic              we_q;
    logic [15:0]       mem [DEPTH];

    logic              is_io;
    logic              is_arr;
    logic [ADDR_W-1:0] idx;

    // Decode of the latched address; the I/O location takes priority over the array.
    assign is_io  = (addr_q == 16'hFFFF);
    assign is_arr = !is_io && ((32'(addr_q) >> ADDR_W) == 32'd0);
    assign idx    = addr_q[ADDR_W-1:0];

    // Request FSM: latch in IDLE, count wait states, do the access, pulse R for one cycle.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            R           <= 1'b0;
            Data_to_CPU <= 16'h0000;
            HEX_out     <= 16'h0000;
            cnt         <= 4'd0;
            addr_q      <= 16'h0000;
            wdat_q      <= 16'h0000;
            we_q        <= 1'b0;
        end else begin
            R <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (MEM_EN) begin
                        addr_q <= MAR;
                        wdat_q <= MDR;
                        we_q   <= WE;
                        if (WAIT_STATES == 0) begin
                            state <= S_ACCESS;
                        end else begin
                            cnt   <= 4'(WAIT_STATES);
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    R     <= 1'b1;
                    state <= S_DONE;
                    if (!we_q) begin
                        if (is_io) begin
                            Data_to_CPU <= Switches;
                        end else if (is_arr) begin
                            Data_to_CPU <= mem[idx];
                        end else begin
                            Data_to_CPU <= 16'h0000;
                        end
                    end else if (is_io) begin
                        HEX_out <= wdat_q;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Array write happens only at the ACCESS edge, so an aborted request never lands; contents survive reset.
    always_ff @(posedge clk) begin
        if (!Reset && state == S_ACCESS && we_q && is_arr) begin
            mem[idx] <= wdat_q;
        end
    end

`ifdef MEM_OOR_FLAG_EN
    // Sticky flag for any access that hits neither the array nor the I/O location.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            oor_err <= 1'b0;
        end else if (state == S_ACCESS && !is_io && !is_arr) begin
            oor_err <= 1'b1;
        end
    end
`endif

endmodule
